// File: rtl/dmem_stage_ctrl_pkg.sv
// Purpose: shared types and constants for the data-memory stage controller.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package dmem_stage_ctrl_pkg;

    // Default datapath width for the DM stage.
    localparam int DM_XLEN = 32;

    // Access size/sign encodings as carried in funct3 of loads and stores.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_REQ  = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

    // Unsigned sizes only make sense for loads; stores accept B/H/W.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
        logic ok;
        case (funct3)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = ~is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_stage_ctrl_align.sv
// Purpose: byte-lane logic for the DM stage: legality/alignment, byte enables, store
//          replication, and load lane extraction with sign/zero extension.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: req_* describe the access being launched (addr low bits, funct3, store flag, rs2);
//        rsp_* describe the access being completed (latched addr low bits, funct3, rdata).
module dmem_align
    import dmem_stage_ctrl_pkg::*;
#(
    parameter int XLEN = DM_XLEN
) (
    input  logic [1:0]        req_lo,
    input  logic [2:0]        req_funct3,
    input  logic              req_store,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              req_ok,
    output logic [XLEN/8-1:0] req_be,
    output logic [XLEN-1:0]   req_wdata_rep,
    input  logic [1:0]        rsp_lo,
    input  logic [2:0]        rsp_funct3,
    input  logic [XLEN-1:0]   rsp_rdata,
    output logic [XLEN-1:0]   rsp_data
);
    localparam int BW = XLEN / 8;

    logic       aligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        aligned       = 1'b1;
        req_be        = '0;
        req_wdata_rep = '0;
        case (req_funct3)
            MEM_B, MEM_BU: begin
                req_be        = {{(BW-1){1'b0}}, 1'b1} << req_lo;
                req_wdata_rep = {(XLEN/8){req_wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                aligned       = ~req_lo[0];
                req_be        = {{(BW-2){1'b0}}, 2'b11} << {req_lo[1], 1'b0};
                req_wdata_rep = {(XLEN/16){req_wdata[15:0]}};
            end
            MEM_W: begin
                aligned       = (req_lo == 2'b00);
                req_be        = {BW{1'b1}};
                req_wdata_rep = req_wdata;
            end
            default: ;
        endcase
        req_ok = aligned & funct3_legal(req_funct3, req_store);
    end

    always_comb begin
        case (rsp_lo)
            2'd0:    ld_byte = rsp_rdata[7:0];
            2'd1:    ld_byte = rsp_rdata[15:8];
            2'd2:    ld_byte = rsp_rdata[23:16];
            default: ld_byte = rsp_rdata[31:24];
        endcase
        ld_half = rsp_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

        case (rsp_funct3)
            MEM_B:   rsp_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            MEM_BU:  rsp_data = {{(XLEN-8){1'b0}}, ld_byte};
            MEM_H:   rsp_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            MEM_HU:  rsp_data = {{(XLEN-16){1'b0}}, ld_half};
            MEM_W:   rsp_data = rsp_rdata;
            default: rsp_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_stage_ctrl.sv
// Purpose: sequences one load/store per EX/DM instruction over a req/gnt/rvalid data bus,
//          stalling the front of the pipeline and raising misalign/bus-error pulses.
// Latency: 3 cycles minimum (detect, request+grant, response); stall_mem drops in the last.
// Backpressure: dbus_req holds with stable addr/be/wdata until dbus_gnt; the response wait
//          is bounded by TIMEOUT cycles, after which a bus error is forced.
// Ports: m_* = EX/DM instruction fields, flush = squash (IDLE only), dbus_* = data bus,
//        stall_mem / m_load_data / load_done / misalign_exc / bus_err_exc = pipeline side.
module dmem_stage_ctrl
    import dmem_stage_ctrl_pkg::*;
#(
    parameter int XLEN    = DM_XLEN,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic [2:0]        m_funct3,
    input  logic [XLEN-1:0]   m_addr,
    input  logic [XLEN-1:0]   m_wdata,
    input  logic              flush,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [XLEN-1:0]   dbus_addr,
    output logic [XLEN/8-1:0] dbus_be,
    output logic [XLEN-1:0]   dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [XLEN-1:0]   dbus_rdata,
    input  logic              dbus_err,
    output logic              stall_mem,
    output logic [XLEN-1:0]   m_load_data,
    output logic              load_done,
    output logic              misalign_exc,
    output logic              bus_err_exc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    dm_state_t state, nxt;

    logic [XLEN-1:0]   addr_q;
    logic [XLEN/8-1:0] be_q;
    logic [XLEN-1:0]   wdata_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nxt;

    logic              mem_op;
    logic              req_ok;
    logic [XLEN/8-1:0] req_be;
    logic [XLEN-1:0]   req_wdata_rep;
    logic [XLEN-1:0]   ld_data;

    logic latch_en, cnt_clr;
    logic stall_c, req_c, done_c, mis_c, berr_c;

    assign mem_op = m_valid & (m_mem_read | m_mem_write) & ~flush;

    dmem_align #(.XLEN(XLEN)) u_align (
        .req_lo        (m_addr[1:0]),
        .req_funct3    (m_funct3),
        .req_store     (m_mem_write),
        .req_wdata     (m_wdata),
        .req_ok        (req_ok),
        .req_be        (req_be),
        .req_wdata_rep (req_wdata_rep),
        .rsp_lo        (addr_q[1:0]),
        .rsp_funct3    (funct3_q),
        .rsp_rdata     (dbus_rdata),
        .rsp_data      (ld_data)
    );

    // Value the counter takes at the end of this RESP cycle (cycles spent in RESP so far,
    // including this one); saturates at TIMEOUT so it never wraps.
    assign cnt_nxt = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DM_IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            cnt_q    <= '0;
        end else begin
            state <= nxt;
            if (latch_en) begin
                addr_q   <= m_addr;
                be_q     <= req_be;
                wdata_q  <= req_wdata_rep;
                we_q     <= m_mem_write;
                funct3_q <= m_funct3;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state == DM_RESP) begin
                cnt_q <= cnt_nxt;
            end
        end
    end

    always_comb begin
        nxt      = state;
        latch_en = 1'b0;
        cnt_clr  = 1'b0;
        stall_c  = 1'b0;
        req_c    = 1'b0;
        done_c   = 1'b0;
        mis_c    = 1'b0;
        berr_c   = 1'b0;
        case (state)
            DM_IDLE: begin
                // Late responses from an abandoned or timed-out access land here and are dropped.
                if (mem_op) begin
                    if (req_ok) begin
                        latch_en = 1'b1;
                        stall_c  = 1'b1;
                        nxt      = DM_REQ;
                    end else begin
                        mis_c = 1'b1;
                    end
                end
            end
            DM_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dbus_gnt) begin
                    cnt_clr = 1'b1;
                    nxt     = DM_RESP;
                end
            end
            DM_RESP: begin
                // A response arriving on the timeout cycle still wins over the forced error.
                if (dbus_rvalid) begin
                    done_c = ~dbus_err;
                    berr_c = dbus_err;
                    nxt    = DM_IDLE;
                end else if (cnt_nxt == CW'(TIMEOUT)) begin
                    berr_c = 1'b1;
                    nxt    = DM_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: nxt = DM_IDLE;
        endcase
    end

    // Every output is forced low while reset is held, so a reset mid-access drops the bus
    // request and the stall immediately regardless of what the pipeline presents.
    assign dbus_req     = req_c & ~reset;
    assign dbus_we      = req_c & ~reset & we_q;
    assign dbus_addr    = (req_c & ~reset) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dbus_be      = (req_c & ~reset) ? be_q : '0;
    assign dbus_wdata   = (req_c & ~reset) ? wdata_q : '0;
    assign stall_mem    = stall_c & ~reset;
    assign load_done    = done_c & ~reset;
    assign misalign_exc = mis_c & ~reset;
    assign bus_err_exc  = berr_c & ~reset;
    assign m_load_data  = (state == DM_RESP && !we_q && !reset) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
module tb_dmem_stage_ctrl;
    localparam int XLEN = 32;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m_valid = 1'b0, m_mem_read = 1'b0, m_mem_write = 1'b0;
    logic [2:0]        m_funct3 = 3'b0;
    logic [XLEN-1:0]   m_addr = '0, m_wdata = '0;
    logic              flush = 1'b0;
    logic              dbus_req, dbus_we;
    logic [XLEN-1:0]   dbus_addr, dbus_wdata;
    logic [XLEN/8-1:0] dbus_be;
    logic              dbus_gnt = 1'b0, dbus_rvalid = 1'b0, dbus_err = 1'b0;
    logic [XLEN-1:0]   dbus_rdata = '0;
    logic              stall_mem, load_done, misalign_exc, bus_err_exc;
    logic [XLEN-1:0]   m_load_data;

    dmem_stage_ctrl #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata), .flush(flush),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .stall_mem(stall_mem), .m_load_data(m_load_data), .load_done(load_done),
        .misalign_exc(misalign_exc), .bus_err_exc(bus_err_exc)
    );

    always #5 clk = ~clk;

    // Bus contract: a response may never coincide with the grant.
    always @(negedge clk) begin
        if (dbus_gnt && dbus_rvalid) $error("bus contract broken: rvalid in the grant cycle");
    end

    typedef struct {
        logic [2:0]  ev;    // {load_done, bus_err_exc, misalign_exc}
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Observations of the last run_access call.
    int          r_nreq, r_ncyc, r_ridx;
    logic [31:0] r_stall, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_stable;

    localparam logic [2:0] EV_DONE = 3'b100, EV_BERR = 3'b010, EV_MIS = 3'b001;

    task automatic idle_inputs();
        m_valid = 0; m_mem_read = 0; m_mem_write = 0; m_funct3 = 0; m_addr = 0; m_wdata = 0;
        flush = 0; dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; dbus_rdata = 0;
    endtask

    // Presents one instruction in EX/DM (called just after a rising edge) and plays the bus
    // slave: grant after gnt_wait request cycles, respond rsp_wait cycles into RESP (-1 never).
    // The instruction leaves EX/DM on the first edge where stall_mem was low. Any completion
    // pulse is popped against the scoreboard.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gnt_wait, input int rsp_wait,
                              input logic [31:0] rdata, input logic err, input logic flush_req);
        bit in_resp = 0, done = 0;
        int resp_cnt = 0;
        logic stall_s, req_s;
        exp_t e;
        r_nreq = 0; r_ncyc = 0; r_ridx = -1; r_stall = '0; r_addr = '0; r_wdata = '0;
        r_be = '0; r_we = 0; r_stable = 1;
        m_valid = 1; m_mem_read = rd; m_mem_write = wr; m_funct3 = f3; m_addr = addr; m_wdata = wd;
        while (!done && r_ncyc < 32) begin
            req_s       = dbus_req;
            dbus_gnt    = req_s && (r_nreq >= gnt_wait);
            dbus_rvalid = in_resp && rsp_wait >= 0 && resp_cnt == rsp_wait;
            dbus_rdata  = dbus_rvalid ? rdata : 32'h0;
            dbus_err    = dbus_rvalid & err;
            flush       = flush_req & req_s;
            @(negedge clk);
            stall_s = stall_mem;
            r_stall[r_ncyc] = stall_s;
            if (dbus_req) begin
                if (r_nreq == 0) begin
                    r_addr = dbus_addr; r_be = dbus_be; r_wdata = dbus_wdata; r_we = dbus_we;
                end else if (dbus_addr !== r_addr || dbus_be !== r_be ||
                             dbus_wdata !== r_wdata || dbus_we !== r_we) begin
                    r_stable = 0;
                end
                r_nreq++;
            end
            if (load_done || bus_err_exc || misalign_exc) begin
                if (in_resp) r_ridx = resp_cnt;
                n_vec++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_unexpected: got ev=%b with no expected event", {load_done, bus_err_exc, misalign_exc});
                end else begin
                    e = sb.pop_front();
                    if ({load_done, bus_err_exc, misalign_exc} !== e.ev) begin
                        n_mis++;
                        $display("FAIL sb_event: got ev=%b want %b", {load_done, bus_err_exc, misalign_exc}, e.ev);
                    end
                    if (e.ev == EV_DONE) begin
                        n_vec++;
                        if (m_load_data !== e.data) begin
                            n_mis++;
                            $display("FAIL sb_load_data: got %h want %h", m_load_data, e.data);
                        end
                    end
                end
            end
            @(posedge clk); #1;
            r_ncyc++;
            if (dbus_gnt) begin in_resp = 1; resp_cnt = 0; end
            else if (in_resp) resp_cnt++;
            if (!stall_s) done = 1;
        end
        idle_inputs();
        if (!done) begin
            n_vec++; n_mis++;
            $display("FAIL access_budget: stall_mem still high after %0d cycles, want release", r_ncyc);
        end
    endtask

    task automatic push(input logic [2:0] ev, input logic [31:0] data);
        exp_t e;
        e.ev = ev; e.data = data;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mem, m_load_data,
             load_done, misalign_exc, bus_err_exc} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: req=%b be=%b stall=%b ld=%h, want all 0", dbus_req, dbus_be, stall_mem, m_load_data);
        end
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        n_vec++;
        if ({dbus_req, stall_mem, load_done, misalign_exc, bus_err_exc} !== 5'b0) begin
            n_mis++;
            $display("FAIL post_reset_idle: req=%b stall=%b, want 0", dbus_req, stall_mem);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        push(EV_DONE, 32'hDEADBEEF);
        run_access(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0, 0);
        n_vec++;
        if (r_addr !== 32'h100 || r_be !== 4'b1111 || r_we !== 1'b0) begin
            n_mis++; $display("FAIL lw_bus: addr=%h be=%b we=%b want 100/1111/0", r_addr, r_be, r_we);
        end
        n_vec++;
        if (r_ncyc != 3 || r_stall[2:0] !== 3'b011) begin
            n_mis++; $display("FAIL lw_stall: cycles=%0d trace=%b want 3 / 011", r_ncyc, r_stall[2:0]);
        end
        n_vec++;
        if (r_nreq != 1) begin n_mis++; $display("FAIL lw_req_cycles: got %0d want 1", r_nreq); end
    endtask

    task automatic test_sub_word_loads();
        push(EV_DONE, 32'hFFFFFF80);
        run_access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FFFF7F, 0, 0);
        n_vec++;
        if (r_be !== 4'b1000 || r_addr !== 32'h100) begin
            n_mis++; $display("FAIL lb_be: be=%b addr=%h want 1000/100", r_be, r_addr);
        end
        push(EV_DONE, 32'h00000080);
        run_access(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FFFF7F, 0, 0);
        push(EV_DONE, 32'hFFFF80FF);
        run_access(1, 0, 3'b001, 32'h102, 0, 0, 1, 32'h80FFFF7F, 0, 0);
        n_vec++;
        if (r_be !== 4'b1100) begin n_mis++; $display("FAIL lh_be: got %b want 1100", r_be); end
        push(EV_DONE, 32'h0000FF7F);
        run_access(1, 0, 3'b101, 32'h100, 0, 1, 0, 32'h80FFFF7F, 0, 0);
        push(EV_DONE, 32'h0000007F);
        run_access(1, 0, 3'b100, 32'h100, 0, 0, 0, 32'h80FFFF7F, 0, 0);
        n_vec++;
        if (r_be !== 4'b0001) begin n_mis++; $display("FAIL lbu_be0: got %b want 0001", r_be); end
    endtask

    task automatic test_store_backpressure();
        push(EV_DONE, 32'h0);
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 4, 1, 32'hFFFFFFFF, 0, 0);
        n_vec++;
        if (r_nreq != 5 || !r_stable) begin
            n_mis++; $display("FAIL sh_req_hold: req cycles=%0d stable=%b want 5/1", r_nreq, r_stable);
        end
        n_vec++;
        if (r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_we !== 1'b1 || r_addr !== 32'h200) begin
            n_mis++; $display("FAIL sh_bus: be=%b wdata=%h we=%b addr=%h want 1100/abcdabcd/1/200", r_be, r_wdata, r_we, r_addr);
        end
        push(EV_DONE, 32'h0);
        run_access(0, 1, 3'b000, 32'h201, 32'h00000055, 0, 0, 0, 0, 0);
        n_vec++;
        if (r_be !== 4'b0010 || r_wdata !== 32'h55555555) begin
            n_mis++; $display("FAIL sb_bus: be=%b wdata=%h want 0010/55555555", r_be, r_wdata);
        end
    endtask

    task automatic test_misalign();
        push(EV_MIS, 0);
        run_access(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (r_nreq != 0 || r_ncyc != 1 || r_stall[0] !== 1'b0) begin
            n_mis++; $display("FAIL lw_misalign: req=%0d cycles=%0d stall=%b want 0/1/0", r_nreq, r_ncyc, r_stall[0]);
        end
        push(EV_MIS, 0);
        run_access(0, 1, 3'b100, 32'h200, 32'h11, 0, 0, 0, 0, 0);
        n_vec++;
        if (r_nreq != 0) begin n_mis++; $display("FAIL sbu_illegal_req: got %0d want 0", r_nreq); end
        push(EV_MIS, 0);
        run_access(1, 0, 3'b001, 32'h103, 0, 0, 0, 0, 0, 0);
        push(EV_MIS, 0);
        run_access(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_bus_errors();
        push(EV_BERR, 0);
        run_access(1, 0, 3'b010, 32'h300, 0, 0, -1, 0, 0, 0);
        n_vec++;
        if (r_ridx != TMO - 1 || r_ncyc != TMO + 2) begin
            n_mis++; $display("FAIL timeout_cycle: resp idx=%0d cycles=%0d want %0d/%0d", r_ridx, r_ncyc, TMO - 1, TMO + 2);
        end
        dbus_rvalid = 1; dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_vec++;
        if (load_done !== 1'b0 || bus_err_exc !== 1'b0 || stall_mem !== 1'b0) begin
            n_mis++; $display("FAIL late_rvalid: done=%b berr=%b stall=%b want 0/0/0", load_done, bus_err_exc, stall_mem);
        end
        @(posedge clk); #1 idle_inputs();
        push(EV_BERR, 0);
        run_access(1, 0, 3'b010, 32'h304, 0, 0, 2, 32'h12345678, 1, 0);
        n_vec++;
        if (r_ncyc != 5) begin n_mis++; $display("FAIL err_resp_cycles: got %0d want 5", r_ncyc); end
    endtask

    task automatic test_reset_mid_access();
        m_valid = 1; m_mem_read = 1; m_funct3 = 3'b010; m_addr = 32'h400;
        @(posedge clk); #1 dbus_gnt = dbus_req;
        @(posedge clk); #1 dbus_gnt = 0;
        @(negedge clk);
        n_vec++;
        if (stall_mem !== 1'b1 || dbus_req !== 1'b0) begin
            n_mis++; $display("FAIL resp_entry: stall=%b req=%b want 1/0", stall_mem, dbus_req);
        end
        reset = 1; #1;
        n_vec++;
        if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_mem, m_load_data,
             load_done, misalign_exc, bus_err_exc} !== '0) begin
            n_mis++; $display("FAIL reset_mid_resp: req=%b stall=%b ld=%h want all 0", dbus_req, stall_mem, m_load_data);
        end
        @(posedge clk); #1 reset = 0; idle_inputs();
        dbus_rvalid = 1; dbus_rdata = 32'h0BADF00D;
        @(negedge clk);
        n_vec++;
        if ({dbus_req, stall_mem, load_done, bus_err_exc} !== 4'b0) begin
            n_mis++; $display("FAIL abandoned_resp: req=%b stall=%b done=%b berr=%b want 0", dbus_req, stall_mem, load_done, bus_err_exc);
        end
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_flush();
        push(EV_DONE, 32'h87654321);
        run_access(1, 0, 3'b010, 32'h104, 0, 2, 0, 32'h87654321, 0, 1);
        n_vec++;
        if (r_nreq != 3 || !r_stable) begin
            n_mis++; $display("FAIL flush_in_req: req cycles=%0d stable=%b want 3/1", r_nreq, r_stable);
        end
        m_valid = 1; m_mem_read = 1; m_funct3 = 3'b010; m_addr = 32'h101; flush = 1;
        @(negedge clk);
        n_vec++;
        if ({stall_mem, misalign_exc, dbus_req} !== 3'b0) begin
            n_mis++; $display("FAIL flush_idle: stall=%b mis=%b req=%b want 0", stall_mem, misalign_exc, dbus_req);
        end
        @(posedge clk); #1 m_addr = 32'h100;
        @(negedge clk);
        n_vec++;
        if ({stall_mem, dbus_req} !== 2'b0) begin
            n_mis++; $display("FAIL flush_idle_aligned: stall=%b req=%b want 0", stall_mem, dbus_req);
        end
        @(posedge clk); #1 idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_store_backpressure();
        test_misalign();
        test_bus_errors();
        test_reset_mid_access();
        test_flush();
        n_vec++;
        if (sb.size() != 0) begin
            n_mis++; $display("FAIL sb_leftover: %0d expected events never seen", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
